// File: rtl/jtag_master_pkg.sv
// Shared state encoding, TAP step constants and sizing helper for the JTAG shift master.
// Defining JTAG_SHIFT_MASTER_RUNTEST_EN adds the RUNTEST dwell state after UPDATE.
package jtag_master_pkg;

  localparam int TLR_STEPS = 5;

  typedef enum logic [3:0] {
    ST_TLR,
    ST_IDLE,
    ST_SEL_DR,
    ST_SEL_IR,
    ST_CAPTURE,
    ST_SHIFT,
    ST_EXIT1,
    ST_UPDATE,
`ifdef JTAG_SHIFT_MASTER_RUNTEST_EN
    ST_RUNTEST,
`endif
    ST_RSP
  } state_t;

  // tms driven during each tck step of the corresponding state
  localparam logic TMS_SEL_DR  = 1'b1;
  localparam logic TMS_SEL_IR  = 1'b1;
  localparam logic TMS_CAPTURE = 1'b0;
  localparam logic TMS_EXIT1   = 1'b1;
  localparam logic TMS_UPDATE  = 1'b0;
  localparam logic TMS_RUNTEST = 1'b0;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// tck divider: each tck half-period lasts CLK_DIV clk cycles while enabled; tck held low otherwise.
// rise_stb/fall_stb mark the clk edge on which tck goes high/low.
module jtag_tck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tck,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          half_done;

  assign half_done = en && (cnt == CNT_TOP);
  assign rise_stb  = half_done && !tck;
  assign fall_stb  = half_done && tck;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (half_done) begin
      cnt <= '0;
      tck <= !tck;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/jtag_shift_master.sv
// JTAG master turning IR/DR scan commands into TAP pin sequences and returning captured TDO bits.
// JTAG_SHIFT_MASTER_RUNTEST_EN: dwell RTI_CYC extra tck steps in Run-Test/Idle before responding.
module jtag_shift_master
  import jtag_master_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int CLK_DIV = 2,
  parameter int RTI_CYC = 1,
  localparam int LEN_W = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_ir,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo
);

  localparam int STEP_W = $clog2(TLR_STEPS + RTI_CYC + 1);

  state_t             state, state_nxt;
  logic [LEN_W-1:0]   len_q, len_clamp, bit_cnt;
  logic [STEP_W-1:0]  step_cnt;
  logic               ir_q, tdo_q;
  logic [MAX_LEN-1:0] shadow, shadow_shift, len_mask;
  logic               tck_en, rise_stb, fall_stb, accept, last_bit;

  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (tck_en),
    .tck      (tck),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  assign tck_en    = (state != ST_IDLE) && (state != ST_RSP);
  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign rsp_valid = (state == ST_RSP);
  assign rsp_data  = shadow;
  assign accept    = cmd_valid && cmd_ready;
  assign last_bit  = (bit_cnt == len_q - LEN_W'(1));
  assign tdi       = (state == ST_SHIFT) && shadow[0];
  assign len_clamp = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) len_mask[i] = (i < int'(len_clamp));
  end

  // Capture lands at the top of the active field so the first TDO bit ends up in bit 0.
  always_comb begin
    shadow_shift = shadow >> 1;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i == int'(len_q) - 1) shadow_shift[i] = tdo_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_TLR;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tms       = 1'b0;
    case (state)
      ST_TLR: begin
        tms = (step_cnt < STEP_W'(TLR_STEPS));
        if (fall_stb && step_cnt == STEP_W'(TLR_STEPS)) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (cmd_valid) state_nxt = (len_clamp == '0) ? ST_RSP : ST_SEL_DR;
      end
      ST_SEL_DR: begin
        tms = TMS_SEL_DR;
        if (fall_stb) state_nxt = ir_q ? ST_SEL_IR : ST_CAPTURE;
      end
      ST_SEL_IR: begin
        tms = TMS_SEL_IR;
        if (fall_stb) state_nxt = ST_CAPTURE;
      end
      // Two steps: into Capture, then into Shift (the TAP captures on the second)
      ST_CAPTURE: begin
        tms = TMS_CAPTURE;
        if (fall_stb && step_cnt == STEP_W'(1)) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        tms = last_bit;
        if (fall_stb && last_bit) state_nxt = ST_EXIT1;
      end
      ST_EXIT1: begin
        tms = TMS_EXIT1;
        if (fall_stb) state_nxt = ST_UPDATE;
      end
      ST_UPDATE: begin
        tms = TMS_UPDATE;
`ifdef JTAG_SHIFT_MASTER_RUNTEST_EN
        if (fall_stb) state_nxt = (RTI_CYC > 0) ? ST_RUNTEST : ST_RSP;
`else
        if (fall_stb) state_nxt = ST_RSP;
`endif
      end
`ifdef JTAG_SHIFT_MASTER_RUNTEST_EN
      ST_RUNTEST: begin
        tms = TMS_RUNTEST;
        if (fall_stb && step_cnt == STEP_W'(RTI_CYC - 1)) state_nxt = ST_RSP;
      end
`endif
      ST_RSP: begin
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_TLR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_cnt <= '0;
      bit_cnt  <= '0;
      len_q    <= '0;
      ir_q     <= 1'b0;
      tdo_q    <= 1'b0;
      shadow   <= '0;
    end else begin
      if (rise_stb) tdo_q <= tdo;
      if (accept) begin
        len_q    <= len_clamp;
        ir_q     <= cmd_ir;
        shadow   <= cmd_data & len_mask;
        bit_cnt  <= '0;
        step_cnt <= '0;
      end else if (fall_stb) begin
        step_cnt <= (state_nxt != state) ? '0 : step_cnt + 1'b1;
        if (state == ST_SHIFT) begin
          shadow  <= shadow_shift;
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtag_shift_master.sv
// Bench for jtag_shift_master: drives scans into a behavioural TAP (IDCODE 0xdeadbeef, IR len 5)
// and compares responses and pin sequences against a scan-level reference model.
module tb_jtag_shift_master;

  localparam int MAX_LEN = 32;
  localparam int LEN_W   = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0, cmd_ir = 1'b0, rsp_ready = 1'b0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic [31:0]      cmd_data = '0;
  logic             cmd_ready, rsp_valid, busy, tck, tms, tdi, tdo;
  logic [31:0]      rsp_data;

  int n_cmp = 0;
  int n_err = 0;

  jtag_shift_master #(.MAX_LEN(MAX_LEN), .CLK_DIV(2), .RTI_CYC(1)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir),
    .cmd_len(cmd_len), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .busy(busy), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Behavioural TAP controller: 16-state machine, IDCODE / BYPASS data registers.
  int          tap_st = 0;
  logic [4:0]  tap_ir = 5'd1;
  logic [31:0] tap_sr = '0;
  int          tap_rl = 1;
  int          rise_cnt = 0;
  bit          tms_log[$];
  bit          tdi_log[$];
  int          rise_cyc[$];

  function automatic int tap_next(input int s, input bit tm);
    case (s)
      0: return tm ? 0 : 1;    1: return tm ? 2 : 1;
      2: return tm ? 9 : 3;    3: return tm ? 5 : 4;
      4: return tm ? 5 : 4;    5: return tm ? 8 : 6;
      6: return tm ? 7 : 6;    7: return tm ? 8 : 4;
      8: return tm ? 2 : 1;    9: return tm ? 0 : 10;
      10: return tm ? 12 : 11; 11: return tm ? 12 : 11;
      12: return tm ? 15 : 13; 13: return tm ? 14 : 13;
      14: return tm ? 15 : 11; default: return tm ? 2 : 1;
    endcase
  endfunction

  initial tdo = 1'b0;

  always @(posedge tck) begin
    rise_cnt++;
    tms_log.push_back(tms);
    tdi_log.push_back(tdi);
    rise_cyc.push_back(cyc);
    case (tap_st)
      0: tap_ir = 5'd1;
      3: begin
        if (tap_ir == 5'd1) begin tap_sr = 32'hdeadbeef; tap_rl = 32; end
        else begin tap_sr = '0; tap_rl = 1; end
      end
      10: begin tap_sr = 32'd1; tap_rl = 5; end
      4, 11: tap_sr = (tap_sr >> 1) | ({31'd0, tdi} << (tap_rl - 1));
      15: tap_ir = tap_sr[4:0];
      default: ;
    endcase
    tap_st = tap_next(tap_st, tms);
  end

  always @(negedge tck) tdo = (tap_st == 4 || tap_st == 11) ? tap_sr[0] : 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    rise_cnt = 0;
    tms_log.delete();
    tdi_log.delete();
    rise_cyc.delete();
  endtask

  // Reference: captured value followed by the TDI bits, truncated to the clamped length.
  function automatic logic [31:0] model_rsp(input bit ir, input int len, input logic [31:0] data,
                                            input logic [4:0] cur_ir);
    longint unsigned cap, m, d;
    int rl, l;
    l = (len > MAX_LEN) ? MAX_LEN : len;
    if (ir) begin cap = 1; rl = 5; end
    else if (cur_ir == 5'd1) begin cap = 64'hdeadbeef; rl = 32; end
    else begin cap = 0; rl = 1; end
    m = (64'd1 << l) - 1;
    d = {32'd0, data} & m;
    return 32'((cap | (d << rl)) & m);
  endfunction

  function automatic int model_rises(input bit ir, input int len);
    int l;
    l = (len > MAX_LEN) ? MAX_LEN : len;
    return (l == 0) ? 0 : l + 5 + int'(ir);
  endfunction

  task automatic issue_cmd(input bit ir, input int len, input logic [31:0] data);
    int t;
    clear_logs();
    @(negedge clk);
    cmd_ir = ir; cmd_len = LEN_W'(len); cmd_data = data; cmd_valid = 1'b1;
    t = 0;
    while (!cmd_ready && t < 500) begin @(negedge clk); t++; end
    if (!cmd_ready) chk("accept_timeout", 0, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output bit ok);
    int t;
    t = 0;
    while (!rsp_valid && t < 2000) begin @(negedge clk); t++; end
    ok = rsp_valid;
  endtask

  task automatic run_cmd(input bit ir, input int len, input logic [31:0] data,
                         output logic [31:0] rsp, output bit ok);
    issue_cmd(ir, len, data);
    wait_rsp(ok);
    rsp = rsp_data;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] r, d, held, exp_r;
    logic [8:0]  v9;
    logic [5:0]  v6;
    logic [3:0]  v4;
    logic [4:0]  m_ir;
    bit          ok, ir, seen;
    int          t, len, rc;

    // Reset values
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tck", tck, 0);
    chk("rst_tms", tms, 1);
    chk("rst_tdi", tdi, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_busy", busy, 1);

    // Test-Logic-Reset sequence
    clear_logs();
    rst = 1'b0;
    t = 0;
    while (!cmd_ready && t < 500) begin @(negedge clk); t++; end
    chk("tlr_ready", cmd_ready, 1);
    chk("tlr_rises", rise_cnt, 6);
    v6 = '0;
    for (int i = 0; i < 6 && i < tms_log.size(); i++) v6[i] = tms_log[i];
    chk("tlr_tms", v6, 6'b011111);
    chk("tck_period", (rise_cyc.size() >= 6) ? rise_cyc[5] - rise_cyc[0] : -1, 20);
    chk("tlr_tap_rti", tap_st, 1);
    m_ir = 5'd1;

    // IR capture pattern, then IDCODE read
    run_cmd(1'b1, 5, 32'h01, r, ok);
    chk("ir_done", ok, 1);
    chk("ir_capture", r, 32'h01);
    m_ir = 5'd1;
    run_cmd(1'b0, 32, 32'h0, r, ok);
    chk("idcode_done", ok, 1);
    chk("idcode", r, 32'hdeadbeef);

    // Short DR scan: full tms sequence and tdi bits
    d = $urandom;
    run_cmd(1'b0, 4, d, r, ok);
    v9 = '0;
    for (int i = 0; i < 9 && i < tms_log.size(); i++) v9[i] = tms_log[i];
    chk("dr4_rises", rise_cnt, 9);
    chk("dr4_tms", v9, 9'b011000001);
    v4 = '0;
    for (int i = 0; i < 4 && (3 + i) < tdi_log.size(); i++) v4[i] = tdi_log[3 + i];
    chk("dr4_tdi", v4, d[3:0]);
    chk("dr4_rsp", r, model_rsp(1'b0, 4, d, m_ir));

    // Zero-length scan
    clear_logs();
    @(negedge clk);
    cmd_ir = 1'b0; cmd_len = '0; cmd_data = 32'hffff_ffff; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    t = 1;
    while (!rsp_valid && t < 10) begin @(negedge clk); t++; end
    chk("len0_latency", (t <= 2), 1);
    chk("len0_rises", rise_cnt, 0);
    chk("len0_rsp", rsp_data, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Response backpressure: held data, no second accept
    d = $urandom;
    issue_cmd(1'b0, 8, d);
    wait_rsp(ok);
    chk("bp_done", ok, 1);
    held = rsp_data;
    chk("bp_rsp", held, model_rsp(1'b0, 8, d, m_ir));
    cmd_ir = 1'b0; cmd_len = LEN_W'(16); cmd_data = $urandom; cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_stable", rsp_data, held);
      chk("bp_cmd_ready", cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    rc = rise_cnt;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    repeat (10) @(negedge clk);
    chk("bp_no_second", rise_cnt, rc);
    chk("bp_idle", cmd_ready, 1);

    // Randomised scans against the reference model
    for (int k = 0; k < 16; k++) begin
      ir = ($urandom_range(0, 3) == 0);
      if (ir) begin
        len = 5;
        d = $urandom;
        d[4:0] = ($urandom_range(0, 1) != 0) ? 5'h01 : 5'h1f;
      end else begin
        len = $urandom_range(0, 40);
        d = $urandom;
      end
      exp_r = model_rsp(ir, len, d, m_ir);
      run_cmd(ir, len, d, r, ok);
      chk("rnd_done", ok, 1);
      chk("rnd_rsp", r, exp_r);
      chk("rnd_rises", rise_cnt, model_rises(ir, len));
      chk("rnd_tap_rti", tap_st, 1);
      if (ir) m_ir = d[4:0];
    end

    // Reset during SHIFT bit 10
    d = $urandom;
    issue_cmd(1'b0, 32, d);
    t = 0;
    while (rise_cnt < 14 && t < 500) begin @(negedge clk); t++; end
    chk("mid_reached", rise_cnt, 14);
    rst = 1'b1;
    #1;
    chk("mid_rst_tck", tck, 0);
    chk("mid_rst_tms", tms, 1);
    chk("mid_rst_busy", busy, 1);
    repeat (3) @(negedge clk);
    clear_logs();
    rst = 1'b0;
    seen = 1'b0;
    t = 0;
    while (!cmd_ready && t < 500) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
      t++;
    end
    chk("mid_no_rsp", seen, 0);
    chk("mid_tlr_rises", rise_cnt, 6);
    chk("mid_tap_rti", tap_st, 1);
    m_ir = 5'd1;
    run_cmd(1'b0, 32, 32'h0, r, ok);
    chk("mid_idcode", r, 32'hdeadbeef);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
